// File: rtl/filter_pkg.sv
// Shared definitions for the 3x3 noise-filter front end.
//   PIX_W       default pixel width in bits
//   WIN_K       number of taps in a 3x3 window
//   WIN_TL..BR  window tap indices in raster order (WIN_CTR is the centre)
//   cnt_width   bits needed to count 0..n-1 (at least 1)
package filter_pkg;

    localparam int PIX_W   = 8;
    localparam int WIN_K   = 9;

    localparam int WIN_TL  = 0;
    localparam int WIN_TC  = 1;
    localparam int WIN_TR  = 2;
    localparam int WIN_ML  = 3;
    localparam int WIN_CTR = 4;
    localparam int WIN_MR  = 5;
    localparam int WIN_BL  = 6;
    localparam int WIN_BC  = 7;
    localparam int WIN_BR  = 8;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line memory, one entry per pixel column.
//   clk    rising-edge clock
//   en     write enable (the read is always live)
//   addr   column address
//   wdata  value written to mem[addr] on the rising edge when en=1
//   rdata  combinational read of mem[addr]; it returns the old contents
//          during a write cycle, which gives read-before-write behaviour
// Contents are not reset.
module line_buffer
    import filter_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 640,
    localparam int AW   = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [N-1:0]  wdata,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-to-window front end: buffers two lines of a raster pixel stream and
// emits one 3x3 window per interior pixel.
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_pixel    raster pixel
//   in_valid    pixel accepted this cycle
//   in_sof      (WIN_FRAME_SYNC_EN only) start of frame, sampled with in_valid
//   act         one-cycle strobe: sw_pixel_1..9 hold a valid window
//   sw_pixel_1..3   row r-2, columns c-2..c
//   sw_pixel_4..6   row r-1, columns c-2..c (sw_pixel_5 is the centre)
//   sw_pixel_7..9   row r,   columns c-2..c (sw_pixel_9 is the newest pixel)
// Optional feature macro: WIN_FRAME_SYNC_EN adds in_sof, which forces the
// pixel it accompanies to position (0,0).
//
// Handshake: in_valid alone qualifies a beat; there is no ready, every beat
// with in_valid=1 is accepted on that rising edge. act rises on the edge that
// accepts pixel (r,c) when r>=2 and c>=2 and stays high for exactly one cycle.
module window_gen_3x3
    import filter_pkg::*;
#(
    parameter int N     = PIX_W,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_pixel,
    input  logic         in_valid,
`ifdef WIN_FRAME_SYNC_EN
    input  logic         in_sof,
`endif
    output logic         act,
    output logic [N-1:0] sw_pixel_1,
    output logic [N-1:0] sw_pixel_2,
    output logic [N-1:0] sw_pixel_3,
    output logic [N-1:0] sw_pixel_4,
    output logic [N-1:0] sw_pixel_5,
    output logic [N-1:0] sw_pixel_6,
    output logic [N-1:0] sw_pixel_7,
    output logic [N-1:0] sw_pixel_8,
    output logic [N-1:0] sw_pixel_9
);

    localparam int CW = cnt_width(IMG_W);
    localparam int RW = cnt_width(IMG_H);

    logic [CW-1:0]  col, cur_col, col_next;
    logic [RW-1:0]  row, cur_row, row_next;
    logic           sof;

    logic [2*N-1:0] lb_rdata;
    logic [2*N-1:0] lb_wdata;
    logic [N-1:0]   lb1_rd;
    logic [N-1:0]   lb2_rd;

    logic [N-1:0]   win [WIN_K];

`ifdef WIN_FRAME_SYNC_EN
    assign sof = in_sof;
`else
    assign sof = 1'b0;
`endif

    // Position of the pixel being accepted this cycle. A start-of-frame beat
    // overrides the counters so that pixel is handled exactly like (0,0).
    always_comb begin
        cur_col  = col;
        cur_row  = row;
        if (in_valid && sof) begin
            cur_col = '0;
            cur_row = '0;
        end

        col_next = cur_col + CW'(1);
        row_next = cur_row;
        if (cur_col == CW'(IMG_W - 1)) begin
            col_next = '0;
            if (cur_row == RW'(IMG_H - 1)) begin
                row_next = '0;
            end else begin
                row_next = cur_row + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            col <= col_next;
            row <= row_next;
        end
    end

    // Both lines share one memory: the low half is line r-1, the high half
    // is line r-2. Writing {old r-1, new pixel} ages both lines in one write.
    assign lb1_rd   = lb_rdata[N-1:0];
    assign lb2_rd   = lb_rdata[2*N-1:N];
    assign lb_wdata = {lb1_rd, in_pixel};

    line_buffer #(
        .N     (2 * N),
        .DEPTH (IMG_W)
    ) u_lines (
        .clk   (clk),
        .en    (in_valid),
        .addr  (cur_col),
        .wdata (lb_wdata),
        .rdata (lb_rdata)
    );

    // Window shifts left by one column; the new column enters on the right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_K; i++) begin
                win[i] <= '0;
            end
        end else if (in_valid) begin
            win[WIN_TL] <= win[WIN_TC];
            win[WIN_TC] <= win[WIN_TR];
            win[WIN_TR] <= lb2_rd;
            win[WIN_ML] <= win[WIN_CTR];
            win[WIN_CTR] <= win[WIN_MR];
            win[WIN_MR] <= lb1_rd;
            win[WIN_BL] <= win[WIN_BC];
            win[WIN_BC] <= win[WIN_BR];
            win[WIN_BR] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act <= 1'b0;
        end else begin
            act <= in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        end
    end

    assign sw_pixel_1 = win[WIN_TL];
    assign sw_pixel_2 = win[WIN_TC];
    assign sw_pixel_3 = win[WIN_TR];
    assign sw_pixel_4 = win[WIN_ML];
    assign sw_pixel_5 = win[WIN_CTR];
    assign sw_pixel_6 = win[WIN_MR];
    assign sw_pixel_7 = win[WIN_BL];
    assign sw_pixel_8 = win[WIN_BC];
    assign sw_pixel_9 = win[WIN_BR];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 with an 8x6 frame whose pixel value is row*16+col.
// The driver pushes the expected window for every interior pixel it sends;
// the monitor pops one entry per act strobe and compares the whole window.
module tb_window_gen_3x3;

    localparam int N     = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int W     = 9 * N;

    localparam logic [W-1:0] FIRST_WIN = 72'h00_01_02_10_11_12_20_21_22;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] in_pixel;
    logic         in_valid;
    logic         in_sof;
    logic         act;
    logic [N-1:0] sw_pixel_1, sw_pixel_2, sw_pixel_3;
    logic [N-1:0] sw_pixel_4, sw_pixel_5, sw_pixel_6;
    logic [N-1:0] sw_pixel_7, sw_pixel_8, sw_pixel_9;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           checks;
    int           errors;
    int           act_count;
    logic         acc_prev;

    window_gen_3x3 #(
        .N     (N),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
`ifdef WIN_FRAME_SYNC_EN
        .in_sof     (in_sof),
`endif
        .act        (act),
        .sw_pixel_1 (sw_pixel_1),
        .sw_pixel_2 (sw_pixel_2),
        .sw_pixel_3 (sw_pixel_3),
        .sw_pixel_4 (sw_pixel_4),
        .sw_pixel_5 (sw_pixel_5),
        .sw_pixel_6 (sw_pixel_6),
        .sw_pixel_7 (sw_pixel_7),
        .sw_pixel_8 (sw_pixel_8),
        .sw_pixel_9 (sw_pixel_9)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] cur_win();
        return {sw_pixel_1, sw_pixel_2, sw_pixel_3,
                sw_pixel_4, sw_pixel_5, sw_pixel_6,
                sw_pixel_7, sw_pixel_8, sw_pixel_9};
    endfunction

    // Window centred on (r-1,c-1) of a frame where pixel = row*16+col.
    function automatic logic [W-1:0] exp_win(input int r, input int c);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w = {w[W-N-1:0], 8'((r - 2 + i) * 16 + (c - 2 + j))};
            end
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_pixel(input int r, input int c, input int max_gap,
                               input bit sof);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = 8'(r * 16 + c);
        if (r >= 2 && c >= 2) exp_q.push_back(exp_win(r, c));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int max_gap);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                drive_pixel(r, c, max_gap, 1'b0);
            end
        end
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", W'(exp_q.size()), W'(0));
    endtask

    task automatic clear_log();
        got_q.delete();
        act_count = 0;
    endtask

    function automatic logic [W-1:0] got_at(input int idx);
        return (got_q.size() > idx) ? got_q[idx] : '1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_prev <= 1'b0;
        else        acc_prev <= in_valid;
    end

    always @(negedge clk) begin
        if (rst_n && act) begin
            logic [W-1:0] got;
            got = cur_win();
            act_count++;
            got_q.push_back(got);
            check("act_after_beat", W'(acc_prev), W'(1));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_act got=%h expected=no window", got);
            end else begin
                check("window", got, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] w;
        checks    = 0;
        errors    = 0;
        act_count = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_pixel  = '0;

        // 1: reset values while held and after release
        repeat (3) @(posedge clk);
        #1;
        check("reset_act", W'(act), W'(0));
        check("reset_sw", cur_win(), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_act", W'(act), W'(0));
        check("post_reset_sw", cur_win(), '0);

        // 2: one continuous frame
        clear_log();
        send_frame(0);
        drain();
        check("t2_count", W'(act_count), W'(24));
        check("t2_first", got_at(0), FIRST_WIN);
        w = got_at(23);
        check("t2_last_ctr", W'(w[39:32]), W'(8'h46));

        // 3: same frame with random gaps
        clear_log();
        send_frame(3);
        drain();
        check("t3_count", W'(act_count), W'(24));
        check("t3_first", got_at(0), FIRST_WIN);

        // 4: two back-to-back frames
        clear_log();
        send_frame(0);
        send_frame(0);
        drain();
        check("t4_count", W'(act_count), W'(48));
        check("t4_f2_first", got_at(24), FIRST_WIN);

        // 5: reset pulsed right after pixel 0x34 is accepted
        clear_log();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (r < 3 || c <= 4) drive_pixel(r, c, 0, 1'b0);
            end
        end
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_act_drop", W'(act), W'(0));
        check("t5_sw_clear", cur_win(), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        send_frame(0);
        drain();
        check("t5_count", W'(act_count), W'(24));
        check("t5_first", got_at(0), FIRST_WIN);

`ifdef WIN_FRAME_SYNC_EN
        // 6: in_sof arrives with what would have been pixel (3,5)
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (r < 3 || c <= 4) drive_pixel(r, c, 0, 1'b0);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        clear_log();
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                drive_pixel(r, c, 0, (r == 0 && c == 0));
            end
        end
        drain();
        check("t6_count", W'(act_count), W'(24));
        check("t6_first", got_at(0), FIRST_WIN);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
